// File: rtl/uart_echo_fifo_pkg.sv
// rtl/uart_echo_fifo_pkg.sv - shared TX FSM encoding, ASCII constants and default depth.
// UART_ECHO_CRLF_EN adds the CRLF state to the TX FSM encoding.
package uart_echo_fifo_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int BYTE_W        = 8;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DONE = 2'd1,
`ifdef UART_ECHO_CRLF_EN
        ST_RELEASE   = 2'd2,
        ST_CRLF      = 2'd3
`else
        ST_RELEASE   = 2'd2
`endif
    } tx_state_e;

endpackage

// File: rtl/uart_echo_fifo_if.sv
// rtl/uart_echo_fifo_if.sv - receiver/transmitter handshake and FIFO status bundle.
interface uart_echo_fifo_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] rx_byte;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_byte;
    logic              tx_send;
    logic              tx_done;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_empty;
    logic              fifo_full;
    logic              overflow;

    modport master (
        output rx_byte, rx_valid, tx_done,
        input  tx_byte, tx_send, fifo_level, fifo_empty, fifo_full, overflow
    );

    modport slave (
        input  rx_byte, rx_valid, tx_done,
        output tx_byte, tx_send, fifo_level, fifo_empty, fifo_full, overflow
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with level counter and sticky overflow.
module uart_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [LVL_W-1:0]  level,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    assign empty    = (level == '0);
    assign full     = (level == LVL_W'(DEPTH));
    assign pop_data = mem[rd_ptr];
    assign pop_ok   = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = push & (~full | pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_echo_fifo.sv
// rtl/uart_echo_fifo.sv - RX edge capture into a FIFO and one-byte-at-a-time TX handshake.
// UART_ECHO_CRLF_EN: a transmitted 0x0D is followed by an inserted 0x0A.
module uart_echo_fifo
    import uart_echo_fifo_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DATA_W = BYTE_W
) (
    input  logic           clk,
    input  logic           rst,
    uart_echo_fifo_if.slave bus
);

    logic              rx_valid_q;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;
    tx_state_e         state_q;
    tx_state_e         state_d;
    logic [DATA_W-1:0] tx_byte_q;
    logic [DATA_W-1:0] tx_byte_d;
    logic              tx_send_q;
    logic              tx_send_d;

    // rx_valid is a level that can stay high for a whole UART frame; push once per rise.
    assign push = bus.rx_valid & ~rx_valid_q;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.rx_byte),
        .pop       (pop),
        .pop_data  (head),
        .level     (bus.fifo_level),
        .empty     (bus.fifo_empty),
        .full      (bus.fifo_full),
        .overflow  (bus.overflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid_q <= 1'b0;
            state_q    <= ST_IDLE;
            tx_byte_q  <= '0;
            tx_send_q  <= 1'b0;
        end else begin
            rx_valid_q <= bus.rx_valid;
            state_q    <= state_d;
            tx_byte_q  <= tx_byte_d;
            tx_send_q  <= tx_send_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        tx_send_d = tx_send_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.fifo_empty) begin
                    pop       = 1'b1;
                    tx_byte_d = head;
                    tx_send_d = 1'b1;
                    state_d   = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.tx_done) begin
                    tx_send_d = 1'b0;
                    state_d   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!bus.tx_done) begin
`ifdef UART_ECHO_CRLF_EN
                    state_d = (tx_byte_q == ASCII_CR) ? ST_CRLF : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef UART_ECHO_CRLF_EN
            ST_CRLF: begin
                tx_byte_d = ASCII_LF;
                tx_send_d = 1'b1;
                state_d   = ST_WAIT_DONE;
            end
`endif
            default: begin
                state_d   = ST_IDLE;
                tx_send_d = 1'b0;
            end
        endcase
    end

    assign bus.tx_byte = tx_byte_q;
    assign bus.tx_send = tx_send_q;

endmodule
